// File: rtl/i2c_target_regfile_if.sv
// I2C pad and host-side signals of the i2c_target_regfile block.
interface i2c_target_regfile_if #(
  parameter int unsigned PTR_W = 3
);
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] dbg_addr;
  logic [7:0]       dbg_rdata;
  logic             busy;

  modport slave (
    input  scl_i, sda_i, dbg_addr,
    output sda_oe, wr_valid, wr_addr, wr_data, dbg_rdata, busy
  );

  modport master (
    output scl_i, sda_i, dbg_addr,
    input  sda_oe, wr_valid, wr_addr, wr_data, dbg_rdata, busy
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target serving a byte-wide register file with auto-incrementing pointer, open-drain SDA.
// Optional 3-sample majority glitch filter on SCL/SDA: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3
) (
  input logic                 clk,
  input logic                 rst,
  i2c_target_regfile_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WR_PTR,
    WR_DATA,
    ACK_WR,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_f;
  logic       sda_f;
  logic       scl_q;
  logic       sda_q;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda_rise;
  logic       sda_fall;
  logic       start_det;
  logic       stop_det;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] ptr_inc;
  logic             sda_oe_r;
  logic             sda_oe_nxt;
  logic             busy_r;
  logic             busy_nxt;
  logic             wr_valid_r;
  logic             wr_valid_nxt;
  logic [PTR_W-1:0] wr_addr_r;
  logic [PTR_W-1:0] wr_addr_nxt;
  logic [7:0]       wr_data_r;
  logic [7:0]       wr_data_nxt;
  logic             reg_we;
  logic             byte_done;
  logic             addr_match;

  logic [7:0] regs [DEPTH];

  // Two-flop synchronizers; idle bus level is high so reset to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  // Majority of the last three synced samples, registered: single-clk pulses never win.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                  (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                  (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign sda_rise   = sda_f & ~sda_q;
  assign sda_fall   = ~sda_f & sda_q;
  assign start_det  = sda_fall & scl_f;
  assign stop_det   = sda_rise & scl_f;
  assign byte_done  = (cnt == BYTE_BITS);
  assign addr_match = (shreg[7:1] == SLAVE_ADDR);
  assign ptr_inc    = ptr + PTR_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; bus conditions override byte handling.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR: begin
          if (scl_fall && byte_done) begin
            state_nxt = addr_match ? ACK_ADDR : IGNORE;
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            state_nxt = shreg[0] ? RD_BYTE : WR_PTR;
          end
        end
        WR_PTR, WR_DATA: begin
          if (scl_fall && byte_done) begin
            state_nxt = ACK_WR;
          end
        end
        ACK_WR: begin
          if (scl_fall) begin
            state_nxt = WR_DATA;
          end
        end
        RD_BYTE: begin
          if (scl_fall && byte_done) begin
            state_nxt = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            state_nxt = sda_f ? IGNORE : RD_BYTE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath and output next values; SDA drive only moves on an SCL fall.
  always_comb begin
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    ptr_nxt      = ptr;
    sda_oe_nxt   = sda_oe_r;
    busy_nxt     = busy_r;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr_r;
    wr_data_nxt  = wr_data_r;
    reg_we       = 1'b0;
    if (start_det || stop_det) begin
      cnt_nxt    = '0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, WR_PTR, WR_DATA: begin
          if (scl_rise && !byte_done) begin
            shreg_nxt = {shreg[6:0], sda_f};
            cnt_nxt   = cnt + CNT_W'(1);
          end else if (scl_fall && byte_done) begin
            cnt_nxt = '0;
            if (state == ADDR) begin
              sda_oe_nxt = addr_match;
              busy_nxt   = addr_match;
            end else if (state == WR_PTR) begin
              ptr_nxt    = shreg[PTR_W-1:0];
              sda_oe_nxt = 1'b1;
            end else begin
              reg_we       = 1'b1;
              wr_valid_nxt = 1'b1;
              wr_addr_nxt  = ptr;
              wr_data_nxt  = shreg;
              ptr_nxt      = ptr_inc;
              sda_oe_nxt   = 1'b1;
            end
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            cnt_nxt = '0;
            if (shreg[0]) begin
              shreg_nxt  = regs[ptr];
              sda_oe_nxt = ~regs[ptr][7];
            end else begin
              sda_oe_nxt = 1'b0;
            end
          end
        end
        ACK_WR: begin
          if (scl_fall) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_rise && !byte_done) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (scl_fall) begin
            // cnt==0 only after a master ACK: first bit of the reloaded byte.
            if (cnt == '0) begin
              sda_oe_nxt = ~shreg[7];
            end else if (byte_done) begin
              sda_oe_nxt = 1'b0;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_nxt = ptr_inc;
            if (!sda_f) begin
              shreg_nxt = regs[ptr_inc];
              cnt_nxt   = '0;
            end else begin
              busy_nxt = 1'b0;
            end
          end
        end
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      ptr        <= '0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      ptr        <= ptr_nxt;
      sda_oe_r   <= sda_oe_nxt;
      busy_r     <= busy_nxt;
      wr_valid_r <= wr_valid_nxt;
      wr_addr_r  <= wr_addr_nxt;
      wr_data_r  <= wr_data_nxt;
      if (reg_we) begin
        regs[ptr] <= shreg;
      end
    end
  end

  // SDA is released combinationally so a reset frees the bus in the cycle it is seen.
  assign bus.sda_oe    = sda_oe_r & ~rst;
  assign bus.busy      = busy_r;
  assign bus.wr_valid  = wr_valid_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.dbg_rdata = regs[bus.dbg_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, vector table, random txns vs register model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned DEPTH = 8;
  localparam int          Q     = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  int   total = 0;
  int   bad   = 0;

  i2c_target_regfile_if #(.PTR_W(PTR_W)) ifc ();

  i2c_target_regfile #(.SLAVE_ADDR(7'h50), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  assign ifc.scl_i = scl_m;
  assign ifc.sda_i = sda_m & ~ifc.sda_oe;

  logic [7:0]       m_regs [DEPTH];
  int               m_ptr;
  logic [PTR_W+7:0] exp_q [$];
  logic [PTR_W+7:0] wr_q  [$];

  always @(negedge clk) if (ifc.wr_valid) wr_q.push_back({ifc.wr_addr, ifc.wr_data});

  typedef struct {
    logic [3:0][7:0] b;
    int              nb;
    bit              ack;
    int              nwr;
    logic [1:0][2:0] a;
    logic [1:0][7:0] d;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    r = ifc.sda_i; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(~send_ack, r);
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic check_wr(input string tag);
    check({tag, " wr count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_q.size()) check($sformatf("%s wr%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      ifc.dbg_addr = PTR_W'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), ifc.dbg_rdata, m_regs[i]);
    end
  endtask

  // Model: first data byte selects the pointer, later bytes land at it and advance it.
  task automatic txn_write(input string tag, input logic [7:0] a8, input logic [3:0][7:0] d, input int n);
    logic ack;
    bit   match;
    match = (a8[7:1] == 7'h50) && !a8[0];
    i2c_start();
    write_byte(a8, ack);
    check({tag, " addr ack"}, ack, match);
    check({tag, " busy"}, ifc.busy, match);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack);
      check($sformatf("%s d%0d ack", tag, i), ack, match);
      if (match) begin
        if (i == 0) m_ptr = int'(d[0]) % DEPTH;
        else begin
          m_regs[m_ptr] = d[i];
          exp_q.push_back({PTR_W'(m_ptr), d[i]});
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
    end
    i2c_stop();
    check({tag, " busy end"}, ifc.busy, 1'b0);
    check_wr(tag);
  endtask

  task automatic txn_read(input string tag, input logic [6:0] a7, input int n, output logic [3:0][7:0] rd);
    logic       ack;
    logic [7:0] d;
    bit         match;
    match = (a7 == 7'h50);
    rd = '0;
    i2c_start();
    write_byte({a7, 1'b1}, ack);
    check({tag, " addr ack"}, ack, match);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, d);
        rd[i] = d;
        check($sformatf("%s rd%0d", tag, i), d, m_regs[m_ptr]);
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      check({tag, " busy after nack"}, ifc.busy, 1'b0);
      check({tag, " sda released"}, ifc.sda_oe, 1'b0);
    end
    i2c_stop();
    check_wr(tag);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic            ack;
    logic            r;
    logic [3:0][7:0] d;
    logic [3:0][7:0] rd;
    logic [6:0]      a7;
    int              n;

    vecs[0] = '{b: {8'h22, 8'h11, 8'h02, 8'hA0}, nb: 4, ack: 1'b1, nwr: 2,
                a: {3'd3, 3'd2}, d: {8'h22, 8'h11}};
    vecs[1] = '{b: {8'hCD, 8'hAB, 8'h07, 8'hA0}, nb: 4, ack: 1'b1, nwr: 2,
                a: {3'd0, 3'd7}, d: {8'hCD, 8'hAB}};
    vecs[2] = '{b: {8'h00, 8'h00, 8'h55, 8'hB0}, nb: 2, ack: 1'b0, nwr: 0,
                a: {3'd7, 3'd2}, d: {8'hAB, 8'h11}};

    ifc.dbg_addr = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("reset sda_oe", ifc.sda_oe, 1'b0);
    check("reset busy", ifc.busy, 1'b0);
    check("reset wr_valid", ifc.wr_valid, 1'b0);
    check("reset wr_addr", ifc.wr_addr, 0);
    check("reset wr_data", ifc.wr_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    d = {8'h00, 8'h00, 8'h5A, 8'h01};
    txn_write("pre", 8'hA0, d, 2);

    // Reset while the target is driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a8;
      a8 = 8'hA0;
      i2c_bit(a8[i], r);
    end
    check("ack driven", ifc.sda_oe, 1'b1);
    check("busy at ack", ifc.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst releases sda", ifc.sda_oe, 1'b0);
    repeat (3) @(negedge clk);
    check("rst busy", ifc.busy, 1'b0);
    m_reset();
    check_regs("rst");
    rst = 1'b0;
    i2c_stop();
    wr_q.delete();

    for (int v = 0; v < 3; v++) begin
      i2c_start();
      for (int j = 0; j < vecs[v].nb; j++) begin
        write_byte(vecs[v].b[j], ack);
        check($sformatf("vec%0d ack%0d", v, j), ack, vecs[v].ack);
        if (j == 0) check($sformatf("vec%0d busy", v), ifc.busy, vecs[v].ack);
      end
      i2c_stop();
      check($sformatf("vec%0d busy end", v), ifc.busy, 1'b0);
      check($sformatf("vec%0d wr count", v), wr_q.size(), vecs[v].nwr);
      for (int k = 0; k < vecs[v].nwr; k++)
        if (k < wr_q.size())
          check($sformatf("vec%0d wr%0d", v, k), wr_q[k], {vecs[v].a[k], vecs[v].d[k]});
      for (int k = 0; k < 2; k++) begin
        ifc.dbg_addr = vecs[v].a[k];
        #1;
        check($sformatf("vec%0d reg%0d", v, k), ifc.dbg_rdata, vecs[v].d[k]);
      end
      wr_q.delete();
      if (vecs[v].ack) begin
        m_ptr = int'(vecs[v].b[1]) % DEPTH;
        for (int j = 2; j < vecs[v].nb; j++) begin
          m_regs[m_ptr] = vecs[v].b[j];
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end
    end

    // Pointer write, repeated START, two-byte read ending in NACK.
    i2c_start();
    write_byte(8'hA0, ack);
    check("rs addr ack", ack, 1'b1);
    write_byte(8'h02, ack);
    check("rs ptr ack", ack, 1'b1);
    m_ptr = 2;
    txn_read("rs", 7'h50, 2, rd);
    check("rs byte0", rd[0], 8'h11);
    check("rs byte1", rd[1], 8'h22);

    // Single-clk SDA low glitch while SCL is high during a data bit.
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    m_ptr = 5;
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1;
    repeat (4) @(negedge clk);
    sda_m = 1'b0;
    @(negedge clk);
    sda_m = 1'b1;
    wait_q();
    check("glitch busy", ifc.busy, FILT);
    scl_m = 1'b0; wait_q();
    for (int i = 0; i < 8; i++) i2c_bit(1'b1, r);
    i2c_stop();
    if (FILT) begin
      m_regs[5] = 8'hFF;
      exp_q.push_back({3'd5, 8'hFF});
      m_ptr = 6;
    end
    check_wr("glitch");
    check_regs("glitch");

    for (int t = 0; t < 16; t++) begin
      a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      n  = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        txn_read($sformatf("rnd%0d", t), a7, n, rd);
      end else begin
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        txn_write($sformatf("rnd%0d", t), {a7, 1'b0}, d, n);
      end
    end
    check_regs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
